// File: rtl/conv_apb_sequencer_pkg.sv
// Shared types and constants for the convolution-job APB sequencer.
// Holds the FSM state encoding, op indices and default register map.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] OP_CFG0  = 3'd0;
    localparam logic [2:0] OP_CFG1  = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_POLL  = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;

    localparam logic [31:0] DEF_ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] DEF_ADDR_CFG0   = 32'h0000_0004;
    localparam logic [31:0] DEF_ADDR_CFG1   = 32'h0000_0008;
    localparam logic [31:0] DEF_ADDR_STATUS = 32'h0000_000C;

endpackage

// File: rtl/conv_apb_sequencer_if.sv
// APB bus between the job sequencer (master) and the CONV engine slave port.
interface conv_apb_sequencer_if;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/conv_apb_sequencer.sv
// Runs one CONV layer job over APB: write CFG0/CFG1, set start, poll status, clear start.
// Latency: 11 cycles start-to-done minimum; each failed poll adds 2+POLL_GAP; waits on PREADY.
module conv_apb_sequencer
    import conv_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_CTRL     = DEF_ADDR_CTRL,
    parameter logic [31:0] ADDR_CFG0     = DEF_ADDR_CFG0,
    parameter logic [31:0] ADDR_CFG1     = DEF_ADDR_CFG1,
    parameter logic [31:0] ADDR_STATUS   = DEF_ADDR_STATUS,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned TIMEOUT_POLLS = 1024
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        start,
    input  logic [31:0] cfg0,
    input  logic [31:0] cfg1,
    output logic        busy,
    output logic        done,
    output logic        error,
    conv_apb_sequencer_if.master apb
);

    localparam int PCW = $clog2(TIMEOUT_POLLS) + 1;
    localparam int GW  = $clog2(POLL_GAP) + 1;
    localparam logic [PCW-1:0] POLL_LIMIT = PCW'(TIMEOUT_POLLS);
    localparam logic [GW-1:0]  GAP_LOAD   = GW'(POLL_GAP - 1);

    state_t         state, state_nxt;
    logic [2:0]     op, op_nxt;
    logic [PCW-1:0] poll_cnt, poll_nxt, poll_inc;
    logic [GW-1:0]  gap_cnt, gap_nxt;
    logic [31:0]    cfg0_q, cfg1_q;
    logic           error_nxt;

    logic        psel_d, penable_d, pwrite_d, busy_d, done_d;
    logic [31:0] paddr_d, pwdata_d, cfg0_src, cfg1_src;

    logic unused_prdata;
    assign unused_prdata = ^apb.PRDATA[31:1];

    // Saturates so a huge TIMEOUT_POLLS can never wrap back past the limit.
    assign poll_inc = (&poll_cnt) ? poll_cnt : poll_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            op       <= OP_CFG0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            error    <= 1'b0;
            cfg0_q   <= '0;
            cfg1_q   <= '0;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            poll_cnt <= poll_nxt;
            gap_cnt  <= gap_nxt;
            error    <= error_nxt;
            if (state == S_IDLE && start) begin
                cfg0_q <= cfg0;
                cfg1_q <= cfg1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        poll_nxt  = poll_cnt;
        gap_nxt   = gap_cnt;
        error_nxt = error;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SETUP;
                    op_nxt    = OP_CFG0;
                    poll_nxt  = '0;
                    error_nxt = 1'b0;
                end
            end
            S_SETUP: state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (apb.PREADY) begin
                    if (apb.PSLVERR) begin
                        // A bus error abandons the job without trying to clear CTRL.
                        error_nxt = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        case (op)
                            OP_POLL: begin
                                if (apb.PRDATA[0]) begin
                                    op_nxt    = OP_CLR;
                                    state_nxt = S_SETUP;
                                end else if (poll_inc == POLL_LIMIT) begin
                                    poll_nxt  = poll_inc;
                                    error_nxt = 1'b1;
                                    op_nxt    = OP_CLR;
                                    state_nxt = S_SETUP;
                                end else begin
                                    poll_nxt  = poll_inc;
                                    gap_nxt   = GAP_LOAD;
                                    state_nxt = S_GAP;
                                end
                            end
                            OP_CLR:  state_nxt = S_FINISH;
                            default: begin
                                op_nxt    = op + 3'd1;
                                state_nxt = S_SETUP;
                            end
                        endcase
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_SETUP;
                else               gap_nxt   = gap_cnt - 1'b1;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // cfg registers are not yet loaded on the accepting edge, so op0 takes the live input.
    assign cfg0_src = (state == S_IDLE) ? cfg0 : cfg0_q;
    assign cfg1_src = (state == S_IDLE) ? cfg1 : cfg1_q;

    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        busy_d    = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS) || (state_nxt == S_GAP);
        done_d    = (state_nxt == S_FINISH);
        if (state_nxt == S_SETUP || state_nxt == S_ACCESS) begin
            psel_d    = 1'b1;
            penable_d = (state_nxt == S_ACCESS);
            case (op_nxt)
                OP_CFG0: begin
                    paddr_d  = ADDR_CFG0;
                    pwrite_d = 1'b1;
                    pwdata_d = cfg0_src;
                end
                OP_CFG1: begin
                    paddr_d  = ADDR_CFG1;
                    pwrite_d = 1'b1;
                    pwdata_d = cfg1_src;
                end
                OP_START: begin
                    paddr_d  = ADDR_CTRL;
                    pwrite_d = 1'b1;
                    pwdata_d = 32'd1;
                end
                OP_POLL: paddr_d = ADDR_STATUS;
                default: begin
                    paddr_d  = ADDR_CTRL;
                    pwrite_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            apb.PSEL    <= psel_d;
            apb.PENABLE <= penable_d;
            apb.PWRITE  <= pwrite_d;
            apb.PADDR   <= paddr_d;
            apb.PWDATA  <= pwdata_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_apb_sequencer.sv
// Bench for conv_apb_sequencer: scripted APB slave plus a cycle-trace model built from job rules.
module tb_conv_apb_sequencer;

    localparam int GAP = 4;
    localparam int TMO = 4;

    typedef struct packed {
        logic        psel;
        logic        pen;
        logic        pwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg0 = '0;
    logic [31:0] cfg1 = '0;
    logic        busy, done, error;

    conv_apb_sequencer_if apb_bus();

    conv_apb_sequencer #(.POLL_GAP(GAP), .TIMEOUT_POLLS(TMO)) dut (
        .CLK(CLK), .RESETN(RESETN), .start(start), .cfg0(cfg0), .cfg1(cfg1),
        .busy(busy), .done(done), .error(error), .apb(apb_bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Slave script for the current job
    int sc_wait_op = 7, sc_wait_n = 0, sc_err_op = 7, sc_nzero = 0;
    int s_reads = 0, s_acc = 0;
    logic [64:0] xfer_log[$];

    function automatic int decode_op(logic w, logic [31:0] a, logic [31:0] d);
        if (a == 32'h04) return 0;
        if (a == 32'h08) return 1;
        if (a == 32'h0C && !w) return 3;
        if (a == 32'h00 && w && d == 32'd1) return 2;
        return 4;
    endfunction

    always @(negedge CLK) begin
        int o;
        if (start) begin
            s_reads = 0;
            s_acc = 0;
            xfer_log.delete();
        end
        if (apb_bus.PSEL && apb_bus.PENABLE) begin
            o = decode_op(apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA);
            if (s_acc < ((o == sc_wait_op) ? sc_wait_n : 0)) begin
                apb_bus.PREADY = 1'b0;
                s_acc++;
            end else begin
                apb_bus.PREADY  = 1'b1;
                apb_bus.PSLVERR = (o == sc_err_op);
                apb_bus.PRDATA  = {31'h1234_5678, (!apb_bus.PWRITE && s_reads >= sc_nzero)};
                if (!apb_bus.PWRITE) s_reads++;
                xfer_log.push_back({apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA});
                s_acc = 0;
            end
        end else begin
            apb_bus.PREADY  = 1'b0;
            apb_bus.PSLVERR = 1'b0;
            apb_bus.PRDATA  = '0;
            s_acc = 0;
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic s, input logic en, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic b, input logic dn, input logic er);
        exp_t e;
        e.psel = s; e.pen = en; e.pwr = w; e.addr = a; e.wdata = d;
        e.busy = b; e.done = dn; e.err = er;
        exp_q.push_back(e);
    endtask

    // Expands a job's transfer list into the expected per-cycle bus picture.
    task automatic build_trace(input logic [31:0] c0, input logic [31:0] c1,
                               input int wop, input int wn, input int eop, input int nz);
        int op, polls, reads;
        logic er, fin, w;
        logic [31:0] a, d;
        op = 0; polls = 0; reads = 0; er = 1'b0; fin = 1'b0;
        while (!fin) begin
            case (op)
                0:       begin a = 32'h04; d = c0;    w = 1'b1; end
                1:       begin a = 32'h08; d = c1;    w = 1'b1; end
                2:       begin a = 32'h00; d = 32'd1; w = 1'b1; end
                3:       begin a = 32'h0C; d = 32'd0; w = 1'b0; end
                default: begin a = 32'h00; d = 32'd0; w = 1'b1; end
            endcase
            push(1'b1, 1'b0, w, a, d, 1'b1, 1'b0, er);
            for (int k = 0; k <= ((op == wop) ? wn : 0); k++)
                push(1'b1, 1'b1, w, a, d, 1'b1, 1'b0, er);
            if (op == eop) begin
                er = 1'b1;
                fin = 1'b1;
            end else if (op == 3) begin
                reads++;
                if (reads > nz) op = 4;
                else begin
                    polls++;
                    if (polls == TMO) begin
                        er = 1'b1;
                        op = 4;
                    end else begin
                        for (int k = 0; k < GAP; k++) push(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, er);
                    end
                end
            end else if (op == 4) fin = 1'b1;
            else op++;
        end
        push(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, er);
    endtask

    task automatic check_trace();
        int cyc;
        exp_t e, a;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            cyc++;
            e = exp_q.pop_front();
            a.psel  = apb_bus.PSEL;
            a.pen   = apb_bus.PENABLE;
            a.pwr   = e.psel ? apb_bus.PWRITE : e.pwr;
            a.addr  = e.psel ? apb_bus.PADDR  : e.addr;
            a.wdata = e.psel ? apb_bus.PWDATA : e.wdata;
            a.busy  = busy;
            a.done  = done;
            a.err   = error;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL trace cycle %0d: got %h expected %h", cyc, a, e);
            end
        end
    endtask

    task automatic run_job(input logic [31:0] c0, input logic [31:0] c1, input int wop,
                           input int wn, input int eop, input int nz, output int len);
        sc_wait_op = wop; sc_wait_n = wn; sc_err_op = eop; sc_nzero = nz;
        cfg0 = c0; cfg1 = c1;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        cfg0 = ~c0; cfg1 = ~c1;
        build_trace(c0, c1, wop, wn, eop, nz);
        len = exp_q.size();
        check_trace();
    endtask

    function automatic int count_reads();
        int n = 0;
        foreach (xfer_log[i]) if (!xfer_log[i][64]) n++;
        return n;
    endfunction

    initial begin
        int len;
        logic found;

        repeat (2) @(negedge CLK);
        check("rst_psel", apb_bus.PSEL, 0);
        check("rst_penable", apb_bus.PENABLE, 0);
        check("rst_pwrite", apb_bus.PWRITE, 0);
        check("rst_paddr", apb_bus.PADDR, 0);
        check("rst_pwdata", apb_bus.PWDATA, 0);
        check("rst_busy_done_err", {busy, done, error}, 0);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);

        // Immediate done
        run_job(32'hA5A5_0001, 32'h5A5A_0002, 7, 0, 7, 0, len);
        check("job1_len", len, 11);
        check("job1_nxfer", xfer_log.size(), 5);
        if (xfer_log.size() == 5) begin
            check("job1_x0", xfer_log[0], {1'b1, 32'h04, 32'hA5A5_0001});
            check("job1_x1", xfer_log[1], {1'b1, 32'h08, 32'h5A5A_0002});
            check("job1_x2", xfer_log[2], {1'b1, 32'h00, 32'h1});
            check("job1_x3", xfer_log[3], {1'b0, 32'h0C, 32'h0});
            check("job1_x4", xfer_log[4], {1'b1, 32'h00, 32'h0});
        end
        @(negedge CLK);
        check("job1_after", {busy, done, error, apb_bus.PSEL}, 0);

        // Three failed polls
        run_job(32'h0000_1111, 32'h0000_2222, 7, 0, 7, 3, len);
        check("job2_len", len, 29);
        check("job2_reads", count_reads(), 4);

        // PREADY stretched on CFG1
        run_job(32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 3, 7, 0, len);
        check("job3_len", len, 14);

        // Slave error on CTRL start write
        run_job(32'h1, 32'h2, 7, 0, 2, 0, len);
        check("job4_len", len, 7);
        check("job4_nxfer", xfer_log.size(), 3);
        repeat (3) @(negedge CLK);
        check("job4_err_sticky", {error, apb_bus.PSEL, busy}, 3'b100);

        // Next start clears error
        run_job(32'h3, 32'h4, 7, 0, 7, 0, len);
        @(negedge CLK);
        check("job5_err_cleared", error, 0);

        // Status never set
        run_job(32'h5, 32'h6, 7, 0, 7, 100, len);
        check("job6_len", len, 29);
        check("job6_reads", count_reads(), 4);
        if (xfer_log.size() > 0)
            check("job6_last", xfer_log[xfer_log.size()-1], {1'b1, 32'h00, 32'h0});
        @(negedge CLK);
        check("job6_err", error, 1);

        // Reset during a stalled status read
        sc_wait_op = 3; sc_wait_n = 5; sc_err_op = 7; sc_nzero = 0;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PADDR == 32'h0C) found = 1'b1;
        end
        check("rst_reach_poll", found, 1);
        #2 RESETN = 1'b0;
        #1 check("rst_mid_drop", {apb_bus.PSEL, apb_bus.PENABLE, busy}, 0);
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_idle", {busy, done, apb_bus.PSEL}, 0);
        run_job(32'h7777_0000, 32'h0000_8888, 7, 0, 7, 0, len);
        check("job7_len", len, 11);
        check("job7_nxfer", xfer_log.size(), 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
